cp0_regfile_mp: RTL and testbench
=================================

Name: cp0_regfile_mp

Overview:
- Parametrised multi-port MIPS32 CP0 register file; successor to the single-ALU-port CP0.
- NUM_PORTS independent MTC0/MFC0 ports, each with its own masked write path.
- Adds: atomic exception-entry and ERET port, Count/Compare timer interrupt, Random decrement against Wired, and an interrupt-request output for the commit stage.
- Sits beside the ROB commit logic. Commit drives the write ports, the exception and the ERET port; the TLB drives the TLBR/TLBP result port.

Parameters:
- NUM_PORTS, 2: number of MTC0/MFC0 ports.
- COUNT_DIV, 2: Count increments once every COUNT_DIV cycles (≥1).
- TLB_ENTRIES, 32: TLB size; sets the Random range and Config1.MMUSize = TLB_ENTRIES-1.
- EBASE_RESET, 32'h8000_0000: reset value of EBase.
- PRID_VALUE, 32'h00FF_0000: constant PRId.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- wr_en  in  NUM_PORTS  per-port MTC0 strobe
- wr_addr  in  NUM_PORTS*5  rd field
- wr_sel  in  NUM_PORTS*3  sel field
- wr_data  in  NUM_PORTS*32  write data
- rd_addr  in  NUM_PORTS*5  MFC0 address
- rd_sel  in  NUM_PORTS*3  MFC0 select
- rd_data  out  NUM_PORTS*32  MFC0 result, combinational
- exc_valid  in  1  exception commit
- exc_code  in  5  ExcCode
- exc_pc  in  32  faulting PC
- exc_bd  in  1  in delay slot
- exc_badva_valid  in  1  BadVAddr update enable
- exc_badva  in  32  faulting address
- eret  in  1  ERET commit
- hw_int  in  6  external interrupt lines
- tlb_wr_valid  in  1  TLBR result write
- tlb_entryhi, tlb_entrylo0, tlb_entrylo1, tlb_pagemask  in  32 each  TLBR data
- tlbp_valid  in  1  TLBP result
- tlbp_hit  in  1  probe hit
- tlbp_index  in  $clog2(TLB_ENTRIES)  probe index
- status_o, cause_o, epc_o, errorepc_o, ebase_o, entryhi_o  out  32 each  live register values
- int_req  out  1  interrupt pending and enabled

Behaviour:
- Reset (rst==0 at posedge):
  - Status = 32'h1040_0004 (CU0, BEV, ERL set).
  - Cause, Count, Compare, Context, PageMask, Wired, EntryHi, EntryLo0/1, Index = 0.
  - Random = TLB_ENTRIES-1; EBase = EBASE_RESET; prescaler = 0.
  - EPC, BadVAddr and ErrorEPC reset to 0.
  - Config: M=1, MT=1. Config1: MMUSize = TLB_ENTRIES-1, IL=3, DL=3, all other fields 0.
- Reads:
  - rd_data[p] is combinational from the current register state; there is no same-cycle write bypass.
  - (addr 15, sel 0) returns PRId; (15, 1) returns EBase; (16, 0) returns Config; (16, 1) returns Config1. Unmapped addr/sel returns 0.
- Writes:
  - Each write is masked by the per-register writable mask constant: reg <= (reg & ~MASK) | (data & MASK).
  - Port conflicts on the same register: the highest port index wins. Writes to different registers in the same cycle all take effect.
- Priority per cycle: exc_valid > eret > tlb_wr_valid/tlbp_valid > write ports.
  - exc_valid or eret discards all port writes in that cycle (younger instructions are flushed).
- Exception entry (exc_valid):
  - If Status.EXL==0: EPC <= exc_bd ? exc_pc-4 : exc_pc, and Cause.BD <= exc_bd.
  - If Status.EXL==1: EPC and BD are unchanged.
  - Always: Cause.ExcCode <= exc_code; Status.EXL <= 1.
  - If exc_badva_valid: BadVAddr <= exc_badva.
- ERET:
  - If Status.ERL: ERL <= 0.
  - Otherwise: EXL <= 0.
  - exc_valid and eret together: the exception wins and the ERET is ignored.
- Count:
  - The prescaler counts 0..COUNT_DIV-1; Count increments when the prescaler wraps.
  - An MTC0 to Count loads wr_data and clears the prescaler.
- Timer:
  - When Count == Compare and Count increments this cycle, Cause.TI and Cause.IP7 are set.
  - An MTC0 to Compare clears TI. TI is sticky otherwise.
- Cause.IP[6:2] <= hw_int[4:0] every cycle. IP7 <= hw_int[5] | TI.
- int_req = Status.IE & ~Status.EXL & ~Status.ERL & |(Cause.IP & Status.IM). Registered-state derived; no extra latency.

Optional Feature:
- Macro: CP0_TLB_REGS_EN.
- Defined:
  - Index, EntryLo0/1, PageMask, Wired, Random and Context exist.
  - tlb_wr_valid loads EntryHi, EntryLo0, EntryLo1 and PageMask, each through its write mask.
  - tlbp_valid loads Index = {~tlbp_hit, 0…, tlbp_index}.
  - Random decrements every cycle. When Random == Wired it wraps to TLB_ENTRIES-1.
  - An MTC0 to Wired also sets Random = TLB_ENTRIES-1.
- Undefined:
  - These registers are absent and read 0.
  - TLB inputs are ignored; Config.MT = 0; Config1.MMUSize = 0.
  - EntryHi stays a plain writable register.

Decomposition:
- Shared package cp0_pkg:
  - Register address localparams (CP0_INDEX…CP0_ERROREPC).
  - Per-register write-mask constants.
  - ExcCode enum.
  - Typedefs for Status and Cause as packed structs.
- One sub-module: cp0_timer (prescaler, Count, Compare match, TI flag).

Test Plan:
- Reset then MFC0 (12, 0) → 32'h1040_0004. MFC0 (15, 1) → EBASE_RESET. MFC0 (16, 1): MMUSize field = 31.
- Port0 and port1 both write Status in the same cycle: 32'h1 on port0, 32'hFF01 on port1 → Status.IM = 8'hFF, IE = 1 (port1 wins).
- exc_valid with exc_pc = 32'hBFC0_0104, exc_bd = 1, code 5'h4, EXL = 0 → EPC = 32'hBFC0_0100, BD = 1, EXL = 1.
  - A second exception with pc 32'h1234 → EPC unchanged, ExcCode updated.
- COUNT_DIV = 2, Compare = 10, IE = 1, IM7 = 1, EXL = ERL = 0 → int_req rises after ~20 cycles.
  - MTC0 Compare → TI and int_req clear the next cycle.
- exc_valid and eret in the same cycle as an MTC0 to EPC → EPC from the exception, EXL = 1, MTC0 dropped.
- With CP0_TLB_REGS_EN defined: Wired = 4 → Random cycles 31…4, then wraps to 31.
  - TLBP miss → Index[31] = 1.

Source files
------------

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register addresses, MTC0 writable masks, ExcCode values
// and the packed Status/Cause layouts.
package cp0_pkg;

  localparam logic [4:0] CP0_INDEX    = 5'd0;
  localparam logic [4:0] CP0_RANDOM   = 5'd1;
  localparam logic [4:0] CP0_ENTRYLO0 = 5'd2;
  localparam logic [4:0] CP0_ENTRYLO1 = 5'd3;
  localparam logic [4:0] CP0_CONTEXT  = 5'd4;
  localparam logic [4:0] CP0_PAGEMASK = 5'd5;
  localparam logic [4:0] CP0_WIRED    = 5'd6;
  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_ENTRYHI  = 5'd10;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;
  localparam logic [4:0] CP0_PRID     = 5'd15;
  localparam logic [4:0] CP0_CONFIG   = 5'd16;
  localparam logic [4:0] CP0_ERROREPC = 5'd30;

  // Bits software may change through MTC0; everything else holds its value.
  localparam logic [31:0] MASK_INDEX    = 32'h0000_003F;
  localparam logic [31:0] MASK_ENTRYLO  = 32'h03FF_FFFF;
  localparam logic [31:0] MASK_CONTEXT  = 32'hFF80_0000;
  localparam logic [31:0] MASK_PAGEMASK = 32'h1FFF_E000;
  localparam logic [31:0] MASK_WIRED    = 32'h0000_003F;
  localparam logic [31:0] MASK_ENTRYHI  = 32'hFFFF_E0FF;
  localparam logic [31:0] MASK_STATUS   = 32'hF040_FF17;
  localparam logic [31:0] MASK_CAUSE    = 32'h0000_0300;
  localparam logic [31:0] MASK_EBASE    = 32'h3FFF_F000;
  localparam logic [31:0] MASK_ALL      = 32'hFFFF_FFFF;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,  EXC_MOD  = 5'd1,  EXC_TLBL = 5'd2,  EXC_TLBS = 5'd3,
    EXC_ADEL = 5'd4,  EXC_ADES = 5'd5,  EXC_IBE  = 5'd6,  EXC_DBE  = 5'd7,
    EXC_SYS  = 5'd8,  EXC_BP   = 5'd9,  EXC_RI   = 5'd10, EXC_CPU  = 5'd11,
    EXC_OV   = 5'd12, EXC_TR   = 5'd13
  } exc_code_e;

  typedef struct packed {
    logic [3:0] cu;
    logic       rp;
    logic       fr;
    logic       re;
    logic       mx;
    logic       px;
    logic       bev;
    logic       ts;
    logic       sr;
    logic       nmi;
    logic       zero0;
    logic [1:0] impl;
    logic [7:0] im;
    logic       kx;
    logic       sx;
    logic       ux;
    logic       um;
    logic       zero1;
    logic       erl;
    logic       exl;
    logic       ie;
  } status_t;

  typedef struct packed {
    logic       bd;
    logic       ti;
    logic [1:0] ce;
    logic       dc;
    logic       pci;
    logic [1:0] zero0;
    logic       iv;
    logic       wp;
    logic [5:0] zero1;
    logic [7:0] ip;
    logic       zero2;
    exc_code_e  exc_code;
    logic [1:0] zero3;
  } cause_t;

  function automatic logic [31:0] mask_wr(input logic [31:0] old_val,
                                          input logic [31:0] new_val,
                                          input logic [31:0] mask);
    return (old_val & ~mask) | (new_val & mask);
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer: prescaled Count, Compare register and sticky timer
// interrupt flag (TI).
module cp0_timer #(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we,
  input  logic [31:0] count_wdata,
  input  logic        compare_we,
  input  logic [31:0] compare_wdata,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        ti_o
);

  localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(COUNT_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [31:0]   count_q, count_d;
  logic [31:0]   compare_q, compare_d;
  logic          ti_q, ti_d;
  logic          tick;

  always_comb begin
    tick      = (presc_q == PRESC_MAX);
    presc_d   = tick ? '0 : presc_q + 1'b1;
    count_d   = tick ? count_q + 32'd1 : count_q;
    compare_d = compare_q;
    // The match is only honoured on the cycle Count actually advances.
    ti_d      = ti_q | (tick & (count_q == compare_q));
    if (compare_we) begin
      compare_d = compare_wdata;
      ti_d      = 1'b0;
    end
    if (count_we) begin
      count_d = count_wdata;
      presc_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      presc_q   <= '0;
      count_q   <= '0;
      compare_q <= '0;
      ti_q      <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      ti_q      <= ti_d;
    end
  end

  assign count_o   = count_q;
  assign compare_o = compare_q;
  assign ti_o      = ti_q;

endmodule

// File: rtl/cp0_regfile_mp.sv
// Multi-port MIPS32 CP0 register file with exception/ERET entry, timer and interrupt request.
// Optional TLB registers (Index, Random, EntryLo0/1, Context, PageMask, Wired) under CP0_TLB_REGS_EN.
module cp0_regfile_mp
  import cp0_pkg::*;
#(
  parameter int          NUM_PORTS   = 2,
  parameter int          COUNT_DIV   = 2,
  parameter int          TLB_ENTRIES = 32,
  parameter logic [31:0] EBASE_RESET = 32'h8000_0000,
  parameter logic [31:0] PRID_VALUE  = 32'h00FF_0000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_PORTS-1:0]           wr_en,
  input  logic [NUM_PORTS*5-1:0]         wr_addr,
  input  logic [NUM_PORTS*3-1:0]         wr_sel,
  input  logic [NUM_PORTS*32-1:0]        wr_data,
  input  logic [NUM_PORTS*5-1:0]         rd_addr,
  input  logic [NUM_PORTS*3-1:0]         rd_sel,
  output logic [NUM_PORTS*32-1:0]        rd_data,
  input  logic                           exc_valid,
  input  logic [4:0]                     exc_code,
  input  logic [31:0]                    exc_pc,
  input  logic                           exc_bd,
  input  logic                           exc_badva_valid,
  input  logic [31:0]                    exc_badva,
  input  logic                           eret,
  input  logic [5:0]                     hw_int,
  input  logic                           tlb_wr_valid,
  input  logic [31:0]                    tlb_entryhi,
  input  logic [31:0]                    tlb_entrylo0,
  input  logic [31:0]                    tlb_entrylo1,
  input  logic [31:0]                    tlb_pagemask,
  input  logic                           tlbp_valid,
  input  logic                           tlbp_hit,
  input  logic [$clog2(TLB_ENTRIES)-1:0] tlbp_index,
  output logic [31:0]                    status_o,
  output logic [31:0]                    cause_o,
  output logic [31:0]                    epc_o,
  output logic [31:0]                    errorepc_o,
  output logic [31:0]                    ebase_o,
  output logic [31:0]                    entryhi_o,
  output logic                           int_req
);

`ifdef CP0_TLB_REGS_EN
  localparam int          IW          = $clog2(TLB_ENTRIES);
  localparam logic [31:0] RANDOM_TOP  = 32'(TLB_ENTRIES - 1);
  localparam logic [31:0] CONFIG_VAL  = 32'h8000_0080;
  localparam logic [31:0] CONFIG1_VAL = {1'b0, 6'(TLB_ENTRIES - 1), 3'd0, 3'd3, 3'd0,
                                         3'd0, 3'd3, 3'd0, 7'd0};
`else
  localparam logic [31:0] CONFIG_VAL  = 32'h8000_0000;
  localparam logic [31:0] CONFIG1_VAL = {1'b0, 6'd0, 3'd0, 3'd3, 3'd0, 3'd0, 3'd3, 3'd0, 7'd0};
`endif

  status_t     status_q, status_d;
  cause_t      cause_q, cause_d, cause_rd;
  logic [31:0] epc_q, epc_d, errorepc_q, errorepc_d;
  logic [31:0] badvaddr_q, badvaddr_d, ebase_q, ebase_d, entryhi_q, entryhi_d;
`ifdef CP0_TLB_REGS_EN
  logic [31:0] index_q, index_d, random_q, random_d, wired_q, wired_d;
  logic [31:0] entrylo0_q, entrylo0_d, entrylo1_q, entrylo1_d;
  logic [31:0] pagemask_q, pagemask_d, context_q, context_d;
`endif

  logic        count_we, compare_we, ti;
  logic [31:0] count_wdata, compare_wdata, count_val, compare_val;

  cp0_timer #(
    .COUNT_DIV(COUNT_DIV)
  ) u_timer (
    .clk          (clk),
    .rst          (rst),
    .count_we     (count_we),
    .count_wdata  (count_wdata),
    .compare_we   (compare_we),
    .compare_wdata(compare_wdata),
    .count_o      (count_val),
    .compare_o    (compare_val),
    .ti_o         (ti)
  );

  always_comb begin
    logic [4:0]  wa;
    logic [2:0]  ws;
    logic [31:0] wd;
    wa            = '0;
    ws            = '0;
    wd            = '0;
    status_d      = status_q;
    cause_d       = cause_q;
    epc_d         = epc_q;
    errorepc_d    = errorepc_q;
    badvaddr_d    = badvaddr_q;
    ebase_d       = ebase_q;
    entryhi_d     = entryhi_q;
    count_we      = 1'b0;
    count_wdata   = '0;
    compare_we    = 1'b0;
    compare_wdata = '0;
    cause_d.ip[6:2] = hw_int[4:0];
    cause_d.ip[7]   = hw_int[5];
`ifdef CP0_TLB_REGS_EN
    index_d    = index_q;
    wired_d    = wired_q;
    entrylo0_d = entrylo0_q;
    entrylo1_d = entrylo1_q;
    pagemask_d = pagemask_q;
    context_d  = context_q;
    random_d   = (random_q == wired_q) ? RANDOM_TOP : random_q - 32'd1;
`endif
    if (exc_valid) begin
      if (!status_q.exl) begin
        epc_d      = exc_bd ? exc_pc - 32'd4 : exc_pc;
        cause_d.bd = exc_bd;
      end
      cause_d.exc_code = exc_code_e'(exc_code);
      status_d.exl     = 1'b1;
      if (exc_badva_valid) badvaddr_d = exc_badva;
    end else if (eret) begin
      if (status_q.erl) status_d.erl = 1'b0;
      else              status_d.exl = 1'b0;
    end else begin
      // Ports applied in ascending order so the highest index wins a conflict.
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (wr_en[p]) begin
          wa = wr_addr[p*5 +: 5];
          ws = wr_sel[p*3 +: 3];
          wd = wr_data[p*32 +: 32];
          if (ws == 3'd1) begin
            if (wa == CP0_PRID) ebase_d = mask_wr(ebase_d, wd, MASK_EBASE);
          end else if (ws == 3'd0) begin
            case (wa)
              CP0_COUNT:    begin count_we = 1'b1; count_wdata = wd; end
              CP0_COMPARE:  begin compare_we = 1'b1; compare_wdata = wd; end
              CP0_STATUS:   status_d   = mask_wr(status_d, wd, MASK_STATUS);
              CP0_CAUSE:    cause_d    = mask_wr(cause_d, wd, MASK_CAUSE);
              CP0_EPC:      epc_d      = mask_wr(epc_d, wd, MASK_ALL);
              CP0_ERROREPC: errorepc_d = mask_wr(errorepc_d, wd, MASK_ALL);
              CP0_ENTRYHI:  entryhi_d  = mask_wr(entryhi_d, wd, MASK_ENTRYHI);
`ifdef CP0_TLB_REGS_EN
              CP0_INDEX:    index_d    = mask_wr(index_d, wd, MASK_INDEX);
              CP0_ENTRYLO0: entrylo0_d = mask_wr(entrylo0_d, wd, MASK_ENTRYLO);
              CP0_ENTRYLO1: entrylo1_d = mask_wr(entrylo1_d, wd, MASK_ENTRYLO);
              CP0_CONTEXT:  context_d  = mask_wr(context_d, wd, MASK_CONTEXT);
              CP0_PAGEMASK: pagemask_d = mask_wr(pagemask_d, wd, MASK_PAGEMASK);
              CP0_WIRED: begin
                wired_d  = mask_wr(wired_d, wd, MASK_WIRED);
                random_d = RANDOM_TOP;
              end
`endif
              default: ;
            endcase
          end
        end
      end
`ifdef CP0_TLB_REGS_EN
      // TLB results override any MTC0 to the same register this cycle.
      if (tlb_wr_valid) begin
        entryhi_d  = mask_wr(entryhi_d, tlb_entryhi, MASK_ENTRYHI);
        entrylo0_d = mask_wr(entrylo0_d, tlb_entrylo0, MASK_ENTRYLO);
        entrylo1_d = mask_wr(entrylo1_d, tlb_entrylo1, MASK_ENTRYLO);
        pagemask_d = mask_wr(pagemask_d, tlb_pagemask, MASK_PAGEMASK);
      end
      if (tlbp_valid) index_d = {~tlbp_hit, {(31-IW){1'b0}}, tlbp_index};
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      status_q   <= status_t'(32'h1040_0004);
      cause_q    <= '0;
      epc_q      <= '0;
      errorepc_q <= '0;
      badvaddr_q <= '0;
      ebase_q    <= EBASE_RESET;
      entryhi_q  <= '0;
`ifdef CP0_TLB_REGS_EN
      index_q    <= '0;
      random_q   <= RANDOM_TOP;
      wired_q    <= '0;
      entrylo0_q <= '0;
      entrylo1_q <= '0;
      pagemask_q <= '0;
      context_q  <= '0;
`endif
    end else begin
      status_q   <= status_d;
      cause_q    <= cause_d;
      epc_q      <= epc_d;
      errorepc_q <= errorepc_d;
      badvaddr_q <= badvaddr_d;
      ebase_q    <= ebase_d;
      entryhi_q  <= entryhi_d;
`ifdef CP0_TLB_REGS_EN
      index_q    <= index_d;
      random_q   <= random_d;
      wired_q    <= wired_d;
      entrylo0_q <= entrylo0_d;
      entrylo1_q <= entrylo1_d;
      pagemask_q <= pagemask_d;
      context_q  <= context_d;
`endif
    end
  end

  // TI lives in the timer; it is folded into the architectural Cause view here.
  always_comb begin
    cause_rd       = cause_q;
    cause_rd.ti    = ti;
    cause_rd.ip[7] = cause_q.ip[7] | ti;
  end

  always_comb begin
    logic [4:0]  ra;
    logic [2:0]  rs;
    logic [31:0] rv;
    rd_data = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      ra = rd_addr[p*5 +: 5];
      rs = rd_sel[p*3 +: 3];
      rv = '0;
      if (rs == 3'd1) begin
        if (ra == CP0_PRID)   rv = ebase_q;
        if (ra == CP0_CONFIG) rv = CONFIG1_VAL;
      end else if (rs == 3'd0) begin
        case (ra)
          CP0_BADVADDR: rv = badvaddr_q;
          CP0_COUNT:    rv = count_val;
          CP0_ENTRYHI:  rv = entryhi_q;
          CP0_COMPARE:  rv = compare_val;
          CP0_STATUS:   rv = status_q;
          CP0_CAUSE:    rv = cause_rd;
          CP0_EPC:      rv = epc_q;
          CP0_PRID:     rv = PRID_VALUE;
          CP0_CONFIG:   rv = CONFIG_VAL;
          CP0_ERROREPC: rv = errorepc_q;
`ifdef CP0_TLB_REGS_EN
          CP0_INDEX:    rv = index_q;
          CP0_RANDOM:   rv = random_q;
          CP0_ENTRYLO0: rv = entrylo0_q;
          CP0_ENTRYLO1: rv = entrylo1_q;
          CP0_CONTEXT:  rv = context_q;
          CP0_PAGEMASK: rv = pagemask_q;
          CP0_WIRED:    rv = wired_q;
`endif
          default:      rv = '0;
        endcase
      end
      rd_data[p*32 +: 32] = rv;
    end
  end

`ifndef CP0_TLB_REGS_EN
  logic tlb_unused;
  assign tlb_unused = ^{tlb_wr_valid, tlb_entryhi, tlb_entrylo0, tlb_entrylo1, tlb_pagemask,
                        tlbp_valid, tlbp_hit, tlbp_index};
`endif

  assign status_o   = status_q;
  assign cause_o    = cause_rd;
  assign epc_o      = epc_q;
  assign errorepc_o = errorepc_q;
  assign ebase_o    = ebase_q;
  assign entryhi_o  = entryhi_q;
  assign int_req    = status_q.ie & ~status_q.exl & ~status_q.erl & |(cause_rd.ip & status_q.im);

endmodule

// File: tb/tb_cp0_regfile_mp.sv
// Scoreboard bench for cp0_regfile_mp: directed stimulus pushes expectations,
// a monitor process pops and compares them against the DUT outputs.
module tb_cp0_regfile_mp;
  import cp0_pkg::*;

  localparam int NP  = 2;
  localparam int TLB = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [NP-1:0]   wr_en = '0;
  logic [NP*5-1:0] wr_addr = '0;
  logic [NP*3-1:0] wr_sel = '0;
  logic [NP*32-1:0] wr_data = '0;
  logic [NP*5-1:0] rd_addr = '0;
  logic [NP*3-1:0] rd_sel = '0;
  logic [NP*32-1:0] rd_data;
  logic        exc_valid = 1'b0, exc_bd = 1'b0, exc_badva_valid = 1'b0, eret = 1'b0;
  logic [4:0]  exc_code = '0;
  logic [31:0] exc_pc = '0, exc_badva = '0;
  logic [5:0]  hw_int = '0;
  logic        tlb_wr_valid = 1'b0, tlbp_valid = 1'b0, tlbp_hit = 1'b0;
  logic [31:0] tlb_entryhi = '0, tlb_entrylo0 = '0, tlb_entrylo1 = '0, tlb_pagemask = '0;
  logic [$clog2(TLB)-1:0] tlbp_index = '0;
  logic [31:0] status_o, cause_o, epc_o, errorepc_o, ebase_o, entryhi_o;
  logic        int_req;

  always #10 clk = ~clk;

  cp0_regfile_mp #(
    .NUM_PORTS  (NP),
    .COUNT_DIV  (2),
    .TLB_ENTRIES(TLB),
    .EBASE_RESET(32'h8000_0000),
    .PRID_VALUE (32'h00FF_0000)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_sel(wr_sel), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_sel(rd_sel), .rd_data(rd_data),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc), .exc_bd(exc_bd),
    .exc_badva_valid(exc_badva_valid), .exc_badva(exc_badva), .eret(eret), .hw_int(hw_int),
    .tlb_wr_valid(tlb_wr_valid), .tlb_entryhi(tlb_entryhi), .tlb_entrylo0(tlb_entrylo0),
    .tlb_entrylo1(tlb_entrylo1), .tlb_pagemask(tlb_pagemask),
    .tlbp_valid(tlbp_valid), .tlbp_hit(tlbp_hit), .tlbp_index(tlbp_index),
    .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o), .errorepc_o(errorepc_o),
    .ebase_o(ebase_o), .entryhi_o(entryhi_o), .int_req(int_req)
  );

  typedef struct {
    string       name;
    int          kind;
    logic [31:0] mask;
    logic [31:0] exp;
  } exp_t;

  exp_t exp_q[$];
  event chk_ev;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   obs_val = 0;

  function automatic logic [31:0] pick(input int kind);
    case (kind)
      0: return rd_data[31:0];
      1: return rd_data[63:32];
      2: return {31'd0, int_req};
      3: return status_o;
      4: return cause_o;
      5: return epc_o;
      6: return errorepc_o;
      7: return ebase_o;
      8: return entryhi_o;
      default: return 32'(obs_val);
    endcase
  endfunction

  always @(chk_ev) begin
    exp_t        e;
    logic [31:0] act;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: check strobe with no expectation queued");
    end else begin
      e   = exp_q.pop_front();
      act = pick(e.kind) & e.mask;
      n_tests++;
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
      end
    end
  end

  task automatic idle();
    wr_en = '0; exc_valid = 1'b0; exc_badva_valid = 1'b0; eret = 1'b0;
    tlb_wr_valid = 1'b0; tlbp_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic step();
    tick(); idle();
  endtask

  task automatic mtc0(input int p, input logic [4:0] a, input logic [2:0] s, input logic [31:0] d);
    wr_en[p] = 1'b1; wr_addr[p*5 +: 5] = a; wr_sel[p*3 +: 3] = s; wr_data[p*32 +: 32] = d;
  endtask

  task automatic rd(input int p, input logic [4:0] a, input logic [2:0] s);
    rd_addr[p*5 +: 5] = a; rd_sel[p*3 +: 3] = s; #1;
  endtask

  task automatic chk(input string name, input int kind, input logic [31:0] mask,
                     input logic [31:0] exp);
    exp_t e;
    e.name = name; e.kind = kind; e.mask = mask; e.exp = exp;
    exp_q.push_back(e);
    -> chk_ev;
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) tick();
    rst = 1'b1;

    // Reset state
    chk("reset_cause", 4, 32'hFFFF_FFFF, 32'h0);
    rd(0, 5'd9, 3'd0);  chk("reset_count", 0, 32'hFFFF_FFFF, 32'h0);
    rd(1, 5'd12, 3'd0); chk("reset_status_rd", 1, 32'hFFFF_FFFF, 32'h1040_0004);
    chk("reset_status_o", 3, 32'hFFFF_FFFF, 32'h1040_0004);
    tick();
    rd(0, 5'd15, 3'd1); chk("reset_ebase", 0, 32'hFFFF_FFFF, 32'h8000_0000);
    rd(1, 5'd15, 3'd0); chk("prid", 1, 32'hFFFF_FFFF, 32'h00FF_0000);
    rd(0, 5'd16, 3'd1);
`ifdef CP0_TLB_REGS_EN
    chk("config1_mmusize", 0, 32'h7E00_0000, 32'h3E00_0000);
    rd(1, 5'd16, 3'd0); chk("config", 1, 32'hFFFF_FFFF, 32'h8000_0080);
`else
    chk("config1_mmusize", 0, 32'h7E00_0000, 32'h0);
    rd(1, 5'd16, 3'd0); chk("config", 1, 32'hFFFF_FFFF, 32'h8000_0000);
`endif
    rd(0, 5'd7, 3'd0);  chk("unmapped_read", 0, 32'hFFFF_FFFF, 32'h0);
    tick();

    // Park the timer far away so the sticky TI from reset is cleared
    mtc0(0, 5'd11, 3'd0, 32'd1000); mtc0(1, 5'd9, 3'd0, 32'd0); step();
    chk("ti_cleared", 4, 32'h4000_8000, 32'h0);

    // Same-register conflict: port1 wins
    mtc0(0, 5'd12, 3'd0, 32'h0000_0001); mtc0(1, 5'd12, 3'd0, 32'h0000_FF01); step();
    rd(0, 5'd12, 3'd0); chk("status_conflict", 0, 32'hFFFF_FFFF, 32'h0000_FF01);

    // Different registers in one cycle
    mtc0(0, 5'd14, 3'd0, 32'hA5A5_0000); mtc0(1, 5'd30, 3'd0, 32'h0000_5A5A); step();
    chk("dual_epc", 5, 32'hFFFF_FFFF, 32'hA5A5_0000);
    chk("dual_errorepc", 6, 32'hFFFF_FFFF, 32'h0000_5A5A);

    mtc0(0, 5'd10, 3'd0, 32'hFFFF_FFFF); mtc0(1, 5'd15, 3'd1, 32'hFFFF_FFFF); step();
    chk("entryhi_mask", 8, 32'hFFFF_FFFF, 32'hFFFF_E0FF);
    chk("ebase_mask", 7, 32'hFFFF_FFFF, 32'hBFFF_F000);

    // Hardware interrupt line into IP2 and int_req
    chk("int_req_idle", 2, 32'h1, 32'h0);
    hw_int = 6'b000001; tick();
    chk("hw_int_ip2", 4, 32'h0000_FC00, 32'h0000_0400);
    chk("int_req_hw", 2, 32'h1, 32'h1);
    hw_int = 6'b000000; tick();
    chk("int_req_hw_drop", 2, 32'h1, 32'h0);

    // Timer: Count reaches 10 after 20 cycles, increments from 10 at cycle 22
    mtc0(0, 5'd9, 3'd0, 32'd0); mtc0(1, 5'd11, 3'd0, 32'd10); step();
    chk("timer_not_yet", 2, 32'h1, 32'h0);
    n = 1;
    while (n < 60 && !int_req) begin
      tick();
      if (!int_req) n++;
    end
    obs_val = n;
    chk("timer_latency", 9, 32'hFFFF_FFFF, 32'd22);
    chk("timer_ti_ip7", 4, 32'h4000_8000, 32'h4000_8000);
    rd(0, 5'd9, 3'd0); chk("timer_count", 0, 32'hFFFF_FFFF, 32'd11);
    repeat (3) tick();
    chk("timer_sticky", 2, 32'h1, 32'h1);
    mtc0(1, 5'd11, 3'd0, 32'd100); step();
    chk("compare_clears_int", 2, 32'h1, 32'h0);
    chk("compare_clears_ti", 4, 32'h4000_8000, 32'h0);

    // Exception entry in a delay slot
    exc_valid = 1'b1; exc_pc = 32'hBFC0_0104; exc_bd = 1'b1; exc_code = EXC_ADEL;
    exc_badva_valid = 1'b1; exc_badva = 32'hDEAD_0000; step();
    chk("exc_epc", 5, 32'hFFFF_FFFF, 32'hBFC0_0100);
    chk("exc_cause", 4, 32'h8000_007C, 32'h8000_0010);
    chk("exc_exl", 3, 32'h0000_0002, 32'h0000_0002);
    rd(0, 5'd8, 3'd0); chk("exc_badvaddr", 0, 32'hFFFF_FFFF, 32'hDEAD_0000);

    // Nested exception: EPC/BD hold, ExcCode updates
    exc_valid = 1'b1; exc_pc = 32'h0000_1234; exc_bd = 1'b0; exc_code = EXC_ADES; step();
    chk("nested_epc", 5, 32'hFFFF_FFFF, 32'hBFC0_0100);
    chk("nested_cause", 4, 32'h8000_007C, 32'h8000_0014);
    chk("nested_badvaddr", 0, 32'hFFFF_FFFF, 32'hDEAD_0000);

    eret = 1'b1; step();
    chk("eret_exl", 3, 32'h0000_0006, 32'h0);

    // Exception + ERET + MTC0 EPC in one cycle
    mtc0(0, 5'd14, 3'd0, 32'hDEAD_BEEF);
    exc_valid = 1'b1; eret = 1'b1; exc_pc = 32'h0000_2000; exc_bd = 1'b0; exc_code = EXC_SYS;
    step();
    chk("combo_epc", 5, 32'hFFFF_FFFF, 32'h0000_2000);
    chk("combo_exl", 3, 32'h0000_0002, 32'h0000_0002);
    chk("combo_code", 4, 32'h0000_007C, 32'h0000_0020);

    // ERET with ERL set clears ERL only
    mtc0(0, 5'd12, 3'd0, 32'h0000_0006); step();
    eret = 1'b1; step();
    chk("eret_erl", 3, 32'h0000_0006, 32'h0000_0002);

`ifdef CP0_TLB_REGS_EN
    mtc0(0, 5'd6, 3'd0, 32'd4); step();
    rd(0, 5'd1, 3'd0); chk("random_reload", 0, 32'hFFFF_FFFF, 32'd31);
    rd(1, 5'd6, 3'd0); chk("wired", 1, 32'hFFFF_FFFF, 32'd4);
    tick(); chk("random_dec", 0, 32'hFFFF_FFFF, 32'd30);
    repeat (26) tick();
    chk("random_floor", 0, 32'hFFFF_FFFF, 32'd4);
    tick(); chk("random_wrap", 0, 32'hFFFF_FFFF, 32'd31);

    tlbp_valid = 1'b1; tlbp_hit = 1'b0; tlbp_index = 5'd5; step();
    rd(0, 5'd0, 3'd0); chk("tlbp_miss", 0, 32'hFFFF_FFFF, 32'h8000_0005);
    tlbp_valid = 1'b1; tlbp_hit = 1'b1; tlbp_index = 5'd3; step();
    chk("tlbp_hit", 0, 32'hFFFF_FFFF, 32'h0000_0003);

    tlb_wr_valid = 1'b1; tlb_entryhi = 32'h1234_5678; tlb_entrylo0 = 32'hFFFF_FFFF;
    tlb_entrylo1 = 32'h0000_0000; tlb_pagemask = 32'hFFFF_FFFF; step();
    chk("tlbr_entryhi", 8, 32'hFFFF_FFFF, 32'h1234_4078);
    rd(0, 5'd2, 3'd0); chk("tlbr_entrylo0", 0, 32'hFFFF_FFFF, 32'h03FF_FFFF);
    rd(1, 5'd5, 3'd0); chk("tlbr_pagemask", 1, 32'hFFFF_FFFF, 32'h1FFF_E000);
`else
    mtc0(0, 5'd6, 3'd0, 32'd4); step();
    rd(0, 5'd6, 3'd0); chk("no_wired", 0, 32'hFFFF_FFFF, 32'h0);
    rd(1, 5'd1, 3'd0); chk("no_random", 1, 32'hFFFF_FFFF, 32'h0);
    tlb_wr_valid = 1'b1; tlb_entryhi = 32'h0000_0000; step();
    chk("tlbr_ignored", 8, 32'hFFFF_FFFF, 32'hFFFF_E0FF);
`endif

    tick();
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_leftover: %0d unchecked, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
